// File: rtl/corrector_pkg.sv
// Shared definitions for the corrector datapath: default symbol width and
// width helpers for the packer and its word FIFO.
package corrector_pkg;

  localparam int M_WIDTH_DEF = 3;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int word_width(input int m_width, input int syms_per_word);
    return m_width * syms_per_word;
  endfunction

  function automatic int syms_width(input int syms_per_word);
    return clog2(syms_per_word + 1);
  endfunction

  function automatic int level_width(input int depth);
    return clog2(depth + 1);
  endfunction

endpackage

// File: rtl/corrector_packer_if.sv
// Symbol input, word output handshake and status bundle of corrector_packer.
// master = upstream/consumer side, slave = the packer.
interface corrector_packer_if #(
  parameter int M_WIDTH       = corrector_pkg::M_WIDTH_DEF,
  parameter int SYMS_PER_WORD = 8,
  parameter int FIFO_DEPTH    = 4
);
  import corrector_pkg::*;

  localparam int W  = word_width(M_WIDTH, SYMS_PER_WORD);
  localparam int SW = syms_width(SYMS_PER_WORD);
  localparam int LW = level_width(FIFO_DEPTH);

  logic [M_WIDTH-1:0] sym_in;
  logic               sym_valid;
  logic               flush;
  logic [W-1:0]       word_out;
  logic [SW-1:0]      word_syms;
  logic               word_valid;
  logic               word_ready;
  logic [LW-1:0]      fifo_level;
  logic               overflow;
  logic               clear_overflow;

  modport master (
    output sym_in, sym_valid, flush, word_ready, clear_overflow,
    input  word_out, word_syms, word_valid, fifo_level, overflow
  );

  modport slave (
    input  sym_in, sym_valid, flush, word_ready, clear_overflow,
    output word_out, word_syms, word_valid, fifo_level, overflow
  );

endinterface

// File: rtl/corrector_packer_fifo.sv
// Synchronous word FIFO: push accepted when not full or when popping in the
// same cycle; head output reads as zero while empty.
module packer_fifo
  import corrector_pkg::*;
#(
  parameter int DW    = 28,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [DW-1:0]              i_data,
  output logic [DW-1:0]              o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [level_width(DEPTH)-1:0] o_level
);

  localparam int AW = clog2(DEPTH);
  localparam int LW = level_width(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [LW-1:0] r_level;
  logic          w_do_pop;
  logic          w_do_push;

  assign o_full    = (r_level == LW'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_level   = r_level;
  assign o_data    = o_empty ? '0 : r_mem[r_rd];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + AW'(1);
      if (w_do_pop)  r_rd <= r_rd + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to zero whenever empty.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= i_data;
  end

endmodule

// File: rtl/corrector_packer.sv
// Packs corrected symbols into words (slot 0 in the LSBs), supports flushing a
// partial word, and queues words for a valid/ready consumer.
module corrector_packer
  import corrector_pkg::*;
#(
  parameter int M_WIDTH       = M_WIDTH_DEF,
  parameter int SYMS_PER_WORD = 8,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  corrector_packer_if.slave  bus
);

  localparam int W  = word_width(M_WIDTH, SYMS_PER_WORD);
  localparam int SW = syms_width(SYMS_PER_WORD);
  localparam int LW = level_width(FIFO_DEPTH);

  logic [SW-1:0]   r_slot;
  logic [W-1:0]    r_pack;
  logic            r_overflow;

  logic [W-1:0]    w_pack_ins;
  logic [SW-1:0]   w_cnt;
  logic            w_complete;
  logic            w_push;
  logic            w_pop;
  logic            w_drop;
  logic            w_full;
  logic            w_empty;
  logic [SW+W-1:0] w_head;
  logic [LW-1:0]   w_level;

  // The incoming symbol is merged before the flush decision, so a flush that
  // coincides with the completing symbol yields exactly one full word.
  always_comb begin
    w_pack_ins = r_pack;
    if (bus.sym_valid) w_pack_ins[M_WIDTH*int'(r_slot) +: M_WIDTH] = bus.sym_in;
  end

  assign w_cnt      = r_slot + SW'(bus.sym_valid);
  assign w_complete = bus.sym_valid && (r_slot == SW'(SYMS_PER_WORD - 1));
  assign w_push     = w_complete || (bus.flush && (w_cnt != '0));
  assign w_pop      = !w_empty && bus.word_ready;
  assign w_drop     = w_push && w_full && !w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot     <= '0;
      r_pack     <= '0;
      r_overflow <= 1'b0;
    end else begin
      // Packing restarts after every push attempt, including a dropped one.
      if (w_push) begin
        r_slot <= '0;
        r_pack <= '0;
      end else begin
        r_slot <= w_cnt;
        r_pack <= w_pack_ins;
      end
      if (w_drop)
        r_overflow <= 1'b1;
      else if (bus.clear_overflow)
        r_overflow <= 1'b0;
    end
  end

  packer_fifo #(
    .DW    (SW + W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  ({w_cnt, w_pack_ins}),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  assign bus.word_out   = w_head[W-1:0];
  assign bus.word_syms  = w_head[W +: SW];
  assign bus.word_valid = !w_empty;
  assign bus.fifo_level = w_level;
  assign bus.overflow   = r_overflow;

endmodule

// File: tb/tb_corrector_packer.sv
// Self-checking bench for corrector_packer against a queue-based word model.
module tb_corrector_packer;

  localparam int M   = 3;
  localparam int SPW = 8;
  localparam int D   = 4;
  localparam int W   = M * SPW;
  localparam int SW  = 4;
  localparam int LW  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  corrector_packer_if #(.M_WIDTH(M), .SYMS_PER_WORD(SPW), .FIFO_DEPTH(D)) bus ();

  corrector_packer #(.M_WIDTH(M), .SYMS_PER_WORD(SPW), .FIFO_DEPTH(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  int           m_part[$];
  logic [W-1:0] m_qw[$];
  int           m_qs[$];
  bit           m_ovf;

  task automatic model_reset();
    m_part.delete();
    m_qw.delete();
    m_qs.delete();
    m_ovf = 1'b0;
  endtask

  function automatic logic [W-1:0] exp_out();
    return (m_qw.size() > 0) ? m_qw[0] : '0;
  endfunction

  function automatic logic [SW-1:0] exp_syms();
    return (m_qs.size() > 0) ? SW'(m_qs[0]) : '0;
  endfunction

  // Drive one cycle of inputs, advance the model, and return 1 ns after the edge.
  task automatic step(input bit v, input int s, input bit f, input bit rdy, input bit clr);
    int sv;
    logic [W-1:0] w;
    @(negedge clk);
    sv = s & 7;
    bus.sym_valid      = v;
    bus.sym_in         = sv[M-1:0];
    bus.flush          = f;
    bus.word_ready     = rdy;
    bus.clear_overflow = clr;
    if (m_qw.size() > 0 && rdy) begin
      void'(m_qw.pop_front());
      void'(m_qs.pop_front());
    end
    if (v) m_part.push_back(sv);
    if (clr) m_ovf = 1'b0;
    if (m_part.size() == SPW || (f && m_part.size() > 0)) begin
      w = '0;
      foreach (m_part[i]) w = w | (W'(m_part[i]) << (M * i));
      if (m_qw.size() < D) begin
        m_qw.push_back(w);
        m_qs.push_back(m_part.size());
      end else begin
        m_ovf = 1'b1;
      end
      m_part.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.sym_valid = 0; bus.sym_in = '0; bus.flush = 0;
    bus.word_ready = 0; bus.clear_overflow = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if (bus.word_valid !== 1'b0) begin n_errors++; $display("FAIL reset.valid got %b exp 0", bus.word_valid); end
    n_checks++;
    if (bus.word_out !== '0) begin n_errors++; $display("FAIL reset.out got %h exp 0", bus.word_out); end
    n_checks++;
    if (bus.word_syms !== '0) begin n_errors++; $display("FAIL reset.syms got %0d exp 0", bus.word_syms); end
    n_checks++;
    if (bus.fifo_level !== '0) begin n_errors++; $display("FAIL reset.level got %0d exp 0", bus.fifo_level); end
    n_checks++;
    if (bus.overflow !== 1'b0) begin n_errors++; $display("FAIL reset.ovf got %b exp 0", bus.overflow); end
    n_checks++;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_full_word();
    for (int i = 0; i < 8; i++) step(1, i, 0, 1, 0);
    if (bus.word_valid !== 1'b1) begin n_errors++; $display("FAIL full.valid got %b exp 1", bus.word_valid); end
    n_checks++;
    if (bus.word_out !== 24'hFAC688) begin n_errors++; $display("FAIL full.out got %h exp FAC688", bus.word_out); end
    n_checks++;
    if (bus.word_syms !== 4'd8) begin n_errors++; $display("FAIL full.syms got %0d exp 8", bus.word_syms); end
    n_checks++;
    step(0, 0, 0, 1, 0);
    if (bus.fifo_level !== 3'd0) begin n_errors++; $display("FAIL full.pop_level got %0d exp 0", bus.fifo_level); end
    n_checks++;
  endtask

  task automatic test_flush();
    step(1, 5, 0, 0, 0);
    step(1, 6, 0, 0, 0);
    step(1, 7, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    if (bus.word_out !== 24'h0001F5) begin n_errors++; $display("FAIL flush.out got %h exp 0001F5", bus.word_out); end
    n_checks++;
    if (bus.word_syms !== 4'd3) begin n_errors++; $display("FAIL flush.syms got %0d exp 3", bus.word_syms); end
    n_checks++;
    step(0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0);
    if (bus.fifo_level !== 3'd0) begin n_errors++; $display("FAIL flush.empty_level got %0d exp 0", bus.fifo_level); end
    n_checks++;
    if (bus.word_valid !== 1'b0) begin n_errors++; $display("FAIL flush.empty_valid got %b exp 0", bus.word_valid); end
    n_checks++;
  endtask

  task automatic test_flush_with_sym();
    for (int i = 0; i < 7; i++) step(1, int'($urandom_range(0, 7)), 0, 0, 0);
    step(1, 3, 1, 0, 0);
    if (bus.fifo_level !== 3'd1) begin n_errors++; $display("FAIL flushsym.level got %0d exp 1", bus.fifo_level); end
    n_checks++;
    if (bus.word_syms !== 4'd8) begin n_errors++; $display("FAIL flushsym.syms got %0d exp 8", bus.word_syms); end
    n_checks++;
    if (bus.word_out[23:21] !== 3'd3) begin n_errors++; $display("FAIL flushsym.top got %0d exp 3", bus.word_out[23:21]); end
    n_checks++;
    if (bus.word_out !== exp_out()) begin n_errors++; $display("FAIL flushsym.out got %h exp %h", bus.word_out, exp_out()); end
    n_checks++;
    step(0, 0, 0, 0, 0);
    if (bus.fifo_level !== 3'd1) begin n_errors++; $display("FAIL flushsym.no_extra got %0d exp 1", bus.fifo_level); end
    n_checks++;
    step(0, 0, 0, 1, 0);
  endtask

  task automatic test_overflow();
    logic [W-1:0] first;
    for (int i = 0; i < 5 * SPW; i++) begin
      step(1, int'($urandom_range(0, 7)), 0, 0, 0);
      if (i == SPW - 1) first = m_qw[0];
    end
    if (bus.fifo_level !== 3'd4) begin n_errors++; $display("FAIL ovf.level got %0d exp 4", bus.fifo_level); end
    n_checks++;
    if (bus.overflow !== 1'b1) begin n_errors++; $display("FAIL ovf.flag got %b exp 1", bus.overflow); end
    n_checks++;
    if (bus.word_out !== first) begin n_errors++; $display("FAIL ovf.head got %h exp %h", bus.word_out, first); end
    n_checks++;
    step(0, 0, 0, 0, 1);
    if (bus.overflow !== 1'b0) begin n_errors++; $display("FAIL ovf.clear got %b exp 0", bus.overflow); end
    n_checks++;
    for (int i = 0; i < SPW - 1; i++) step(1, int'($urandom_range(0, 7)), 0, 0, 0);
    step(1, int'($urandom_range(0, 7)), 0, 0, 1);
    if (bus.overflow !== 1'b1) begin n_errors++; $display("FAIL ovf.set_wins got %b exp 1", bus.overflow); end
    n_checks++;
    for (int i = 0; i < D; i++) begin
      step(0, 0, 0, 1, 0);
      if (bus.word_out !== exp_out()) begin n_errors++; $display("FAIL ovf.drain%0d got %h exp %h", i, bus.word_out, exp_out()); end
      n_checks++;
    end
  endtask

  task automatic test_full_pop();
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < D * SPW + SPW - 1; i++) step(1, int'($urandom_range(0, 7)), 0, 0, 0);
    step(1, int'($urandom_range(0, 7)), 0, 1, 0);
    if (bus.overflow !== 1'b0) begin n_errors++; $display("FAIL fullpop.ovf got %b exp 0", bus.overflow); end
    n_checks++;
    if (bus.fifo_level !== 3'd4) begin n_errors++; $display("FAIL fullpop.level got %0d exp 4", bus.fifo_level); end
    n_checks++;
    for (int i = 0; i < D; i++) begin
      if (bus.word_out !== exp_out()) begin n_errors++; $display("FAIL fullpop.order%0d got %h exp %h", i, bus.word_out, exp_out()); end
      n_checks++;
      step(0, 0, 0, 1, 0);
    end
    if (bus.word_valid !== 1'b0) begin n_errors++; $display("FAIL fullpop.drained got %b exp 0", bus.word_valid); end
    n_checks++;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2 * SPW + 4; i++) step(1, int'($urandom_range(1, 7)), 0, 0, 0);
    #2;
    bus.sym_valid = 0; bus.flush = 0; bus.word_ready = 0; bus.clear_overflow = 0;
    rst_n = 1'b0;
    #1;
    if (bus.word_valid !== 1'b0) begin n_errors++; $display("FAIL arst.valid got %b exp 0", bus.word_valid); end
    n_checks++;
    if (bus.word_out !== '0) begin n_errors++; $display("FAIL arst.out got %h exp 0", bus.word_out); end
    n_checks++;
    if (bus.word_syms !== '0) begin n_errors++; $display("FAIL arst.syms got %0d exp 0", bus.word_syms); end
    n_checks++;
    if (bus.fifo_level !== '0) begin n_errors++; $display("FAIL arst.level got %0d exp 0", bus.fifo_level); end
    n_checks++;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < SPW; i++) step(1, int'($urandom_range(0, 7)), 0, 0, 0);
    if (bus.fifo_level !== 3'd1) begin n_errors++; $display("FAIL arst.new_level got %0d exp 1", bus.fifo_level); end
    n_checks++;
    if (bus.word_out !== exp_out()) begin n_errors++; $display("FAIL arst.new_word got %h exp %h", bus.word_out, exp_out()); end
    n_checks++;
    step(0, 0, 0, 1, 0);
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      step(($urandom % 4) != 0, int'($urandom_range(0, 7)), ($urandom % 10) == 0,
           ($urandom % 3) != 0, ($urandom % 16) == 0);
      if (bus.word_valid !== (m_qw.size() > 0)) begin n_errors++; $display("FAIL rand.valid cyc %0d got %b exp %b", c, bus.word_valid, m_qw.size() > 0); end
      n_checks++;
      if (bus.word_out !== exp_out()) begin n_errors++; $display("FAIL rand.out cyc %0d got %h exp %h", c, bus.word_out, exp_out()); end
      n_checks++;
      if (bus.word_syms !== exp_syms()) begin n_errors++; $display("FAIL rand.syms cyc %0d got %0d exp %0d", c, bus.word_syms, exp_syms()); end
      n_checks++;
      if (bus.fifo_level !== LW'(m_qw.size())) begin n_errors++; $display("FAIL rand.level cyc %0d got %0d exp %0d", c, bus.fifo_level, m_qw.size()); end
      n_checks++;
      if (bus.overflow !== m_ovf) begin n_errors++; $display("FAIL rand.ovf cyc %0d got %b exp %b", c, bus.overflow, m_ovf); end
      n_checks++;
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_flush();
    test_flush_with_sym();
    test_overflow();
    test_full_pop();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
